// File: rtl/two_opt_eval_pkg.sv
// Shared types and widths for the 2-opt move evaluator: move record, command codes,
// datapath widths and the exp-table index saturation helper.
package two_opt_eval_pkg;

  localparam int CITY_NUM   = 30;
  localparam int CITY_W     = $clog2(CITY_NUM + 2);
  localparam int DIST_W     = 16;
  localparam int DELTA_W    = DIST_W + 2;
  localparam int BETA_W     = 16;
  localparam int BETA_SHIFT = 8;
  localparam int EXP_AW     = 10;
  localparam int RAND_W     = 32;
  localparam int BASE_W     = 8;
  localparam int PROD_W     = DELTA_W - 1 + BETA_W;

  typedef enum logic [1:0] {
    COM_NOP = 2'd0,
    COM_TWO = 2'd1,
    COM_THR = 2'd2
  } com_t;

  typedef struct packed {
    com_t               com;
    logic [BASE_W-1:0]  base_id;
    logic [CITY_W-1:0]  k;
    logic [CITY_W-1:0]  l;
    logic [RAND_W-1:0]  r_metropolis;
    logic [RAND_W-1:0]  r_exchange;
  } opt_t;

  // Scaled delta*beta clipped to the last exp-table entry.
  function automatic logic [EXP_AW-1:0] sat_exp_idx(input logic [PROD_W-1:0] v);
    return (|v[PROD_W-1:EXP_AW]) ? {EXP_AW{1'b1}} : v[EXP_AW-1:0];
  endfunction

endpackage

// File: rtl/two_opt_eval_if.sv
// Move-in / result-out bundle of the 2-opt evaluator plus its FSM state for observation.
// opt_valid is a one-cycle pulse taken only while busy=0; res_valid is a one-cycle pulse, no back-pressure.
interface two_opt_eval_if import two_opt_eval_pkg::*; ();

  logic                       opt_valid;
  opt_t                       opt;
  logic [BETA_W-1:0]          beta;
  logic                       busy;
  logic                       res_valid;
  opt_t                       res_opt;
  logic                       accept;
  logic signed [DELTA_W-1:0]  delta;
  logic [2:0]                 state_dbg;

  modport master (
    output opt_valid, opt, beta,
    input  busy, res_valid, res_opt, accept, delta, state_dbg
  );

  modport slave (
    input  opt_valid, opt, beta,
    output busy, res_valid, res_opt, accept, delta, state_dbg
  );

endinterface

// File: rtl/two_opt_eval_metropolis_cmp.sv
// Two-cycle Metropolis test: first cycle drives the exp-table address from delta*beta,
// second cycle compares the random draw against the returned threshold.
module two_opt_eval_metropolis_cmp import two_opt_eval_pkg::*; (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      enable,
  input  logic signed [DELTA_W-1:0] delta,
  input  logic [BETA_W-1:0]         beta,
  input  logic [RAND_W-1:0]         r,
  input  logic [31:0]               exp_data,
  output logic [EXP_AW-1:0]         exp_addr,
  output logic                      accept
);

  logic              nonpos;
  logic              nonpos_q;
  logic              en_q;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] scaled;

  assign nonpos = delta[DELTA_W-1] || (delta == '0);
  assign prod   = PROD_W'(delta[DELTA_W-2:0]) * PROD_W'(beta);
  assign scaled = prod >> BETA_SHIFT;

  // Downhill moves never consult the table, so the address stays at 0 for them.
  assign exp_addr = (start && enable && !nonpos) ? sat_exp_idx(scaled) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      nonpos_q <= 1'b1;
      en_q     <= 1'b0;
    end else if (start) begin
      nonpos_q <= nonpos;
      en_q     <= enable;
    end
  end

  assign accept = en_q && (nonpos_q || (r < exp_data));

endmodule

// File: rtl/two_opt_eval.sv
// Evaluates one 2-opt move: reads four tour endpoints and four edge lengths, forms the
// tour-length delta and applies the Metropolis test; fixed 14-cycle latency, one move in flight.
module two_opt_eval import two_opt_eval_pkg::*; (
  input  logic                  clk,
  input  logic                  reset,
  two_opt_eval_if.slave         mv,
  output logic [CITY_W-1:0]     ord_addr,
  input  logic [CITY_W-1:0]     ord_data,
  output logic [2*CITY_W-1:0]   dist_addr,
  input  logic [DIST_W-1:0]     dist_data,
  output logic [EXP_AW-1:0]     exp_addr,
  input  logic [31:0]           exp_data
);

  // The *_WAIT states absorb the one-cycle read latency of the last request of each burst.
  typedef enum logic [2:0] {
    S_IDLE, S_ORD, S_ORD_WAIT, S_DIST, S_DIST_WAIT, S_CALC, S_EXP, S_DONE
  } eval_state_t;

  eval_state_t               state, state_nxt;
  logic [1:0]                step;
  opt_t                      opt_q, res_opt_q;
  logic [BETA_W-1:0]         beta_q;
  logic [CITY_W-1:0]         city_q [4];
  logic [DIST_W-1:0]         dist_q [4];
  logic                      cap_ord, cap_dist;
  logic [1:0]                cap_idx;
  logic signed [DELTA_W-1:0] delta_sum, delta_q, delta_out;
  logic                      accept_q, cmp_accept, is_two, cmp_start;

  assign is_two    = (opt_q.com == COM_TWO);
  assign cmp_start = (state == S_EXP) && (step == 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= (state_nxt != state) ? 2'd0 : step + 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (mv.opt_valid) state_nxt = S_ORD;
      S_ORD:       if (step == 2'd3) state_nxt = S_ORD_WAIT;
      S_ORD_WAIT:  state_nxt = S_DIST;
      S_DIST:      if (step == 2'd3) state_nxt = S_DIST_WAIT;
      S_DIST_WAIT: state_nxt = S_CALC;
      S_CALC:      state_nxt = S_EXP;
      S_EXP:       if (step == 2'd1) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // a,b,c,d = tour[K-1], tour[K], tour[L], tour[L+1]; edges (a,c),(b,d),(a,b),(c,d).
  always_comb begin
    ord_addr     = '0;
    dist_addr    = '0;
    mv.busy      = (state != S_IDLE);
    mv.res_valid = (state == S_DONE);
    mv.state_dbg = state;
    if (is_two && state == S_ORD) begin
      unique case (step)
        2'd0: ord_addr = opt_q.k - CITY_W'(1);
        2'd1: ord_addr = opt_q.k;
        2'd2: ord_addr = opt_q.l;
        2'd3: ord_addr = opt_q.l + CITY_W'(1);
      endcase
    end
    if (is_two && state == S_DIST) begin
      unique case (step)
        2'd0: dist_addr = {city_q[0], city_q[2]};
        2'd1: dist_addr = {city_q[1], city_q[3]};
        2'd2: dist_addr = {city_q[0], city_q[1]};
        2'd3: dist_addr = {city_q[2], city_q[3]};
      endcase
    end
  end

  assign delta_sum = $signed({2'b00, dist_q[0]}) + $signed({2'b00, dist_q[1]})
                   - $signed({2'b00, dist_q[2]}) - $signed({2'b00, dist_q[3]});

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_ord   <= 1'b0;
      cap_dist  <= 1'b0;
      cap_idx   <= '0;
      opt_q     <= '0;
      beta_q    <= '0;
      delta_q   <= '0;
      delta_out <= '0;
      accept_q  <= 1'b0;
      res_opt_q <= '0;
    end else begin
      cap_ord  <= (state == S_ORD);
      cap_dist <= (state == S_DIST);
      cap_idx  <= step;
      if (state == S_IDLE && mv.opt_valid) begin
        opt_q  <= mv.opt;
        beta_q <= mv.beta;
      end
      if (cap_ord)  city_q[cap_idx] <= ord_data;
      if (cap_dist) dist_q[cap_idx] <= dist_data;
      if (state == S_CALC) delta_q <= is_two ? delta_sum : '0;
      // Result registers change only here, so they hold until the next result.
      if (state == S_EXP && step == 2'd1) begin
        accept_q  <= cmp_accept;
        delta_out <= delta_q;
        res_opt_q <= opt_q;
      end
    end
  end

  two_opt_eval_metropolis_cmp u_cmp (
    .clk      (clk),
    .reset    (reset),
    .start    (cmp_start),
    .enable   (is_two),
    .delta    (delta_q),
    .beta     (beta_q),
    .r        (opt_q.r_metropolis),
    .exp_data (exp_data),
    .exp_addr (exp_addr),
    .accept   (cmp_accept)
  );

  assign mv.accept  = accept_q;
  assign mv.delta   = delta_out;
  assign mv.res_opt = res_opt_q;

endmodule

// File: tb/tb_two_opt_eval.sv
// Bench for two_opt_eval: behavioural tour/distance/exp memories, a move model feeding an
// expected-result queue, and address traces captured per move.
module tb_two_opt_eval;
  import two_opt_eval_pkg::*;

  localparam int OPT_W = $bits(opt_t);
  localparam int EXP_W = 1 + DELTA_W + OPT_W;
  localparam int NC    = 2 ** CITY_W;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 reset;
  logic [CITY_W-1:0]    ord_addr, ord_data;
  logic [2*CITY_W-1:0]  dist_addr;
  logic [DIST_W-1:0]    dist_data;
  logic [EXP_AW-1:0]    exp_addr;
  logic [31:0]          exp_data;
  int                   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  two_opt_eval_if bus ();

  two_opt_eval dut (
    .clk       (clk),
    .reset     (reset),
    .mv        (bus),
    .ord_addr  (ord_addr),
    .ord_data  (ord_data),
    .dist_addr (dist_addr),
    .dist_data (dist_data),
    .exp_addr  (exp_addr),
    .exp_data  (exp_data)
  );

  // ---------------- memories ----------------
  logic [CITY_W-1:0] ord_mem [NC];
  logic [DIST_W-1:0] dist_mem [NC][NC];
  int                xc [NC];
  int                yc [NC];
  int                exp_mode;   // 0: table function, 1: constant, 2: unknown
  logic [31:0]       exp_const;

  function automatic logic [31:0] exp_fn(input int i);
    return 32'hFFFF_FFFF - 32'(i) * 32'd4194304;
  endfunction

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  always @(posedge clk) begin
    ord_data  <= ord_mem[ord_addr];
    dist_data <= dist_mem[dist_addr[2*CITY_W-1:CITY_W]][dist_addr[CITY_W-1:0]];
    exp_data  <= (exp_mode == 0) ? exp_fn(int'(exp_addr)) :
                 (exp_mode == 1) ? exp_const : 32'hxxxx_xxxx;
  end

  task automatic fill_dist();
    for (int i = 0; i < NC; i++)
      for (int j = 0; j < NC; j++)
        dist_mem[i][j] = DIST_W'(isqrt((xc[i] - xc[j]) * (xc[i] - xc[j]) +
                                       (yc[i] - yc[j]) * (yc[i] - yc[j])));
  endtask

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard + model ----------------
  logic [EXP_W-1:0] exp_q [$];
  int               t0_q [$];
  int               n_res = 0;
  int               viol = 0;
  longint           model_idx;

  task automatic push_expect(input opt_t o, input logic [BETA_W-1:0] b);
    int a, bb, c, d;
    longint dl, idx;
    logic acc;
    logic [31:0] thr;
    dl = 0; acc = 1'b0; idx = 0;
    if (o.com == COM_TWO) begin
      a  = int'(ord_mem[int'(o.k) - 1]);
      bb = int'(ord_mem[int'(o.k)]);
      c  = int'(ord_mem[int'(o.l)]);
      d  = int'(ord_mem[int'(o.l) + 1]);
      dl = longint'(dist_mem[a][c]) + longint'(dist_mem[bb][d])
         - longint'(dist_mem[a][bb]) - longint'(dist_mem[c][d]);
      if (dl <= 0) acc = 1'b1;
      else begin
        idx = (dl * longint'(b)) >> BETA_SHIFT;
        if (idx > (1 << EXP_AW) - 1) idx = (1 << EXP_AW) - 1;
        thr = (exp_mode == 0) ? exp_fn(int'(idx)) : exp_const;
        acc = (o.r_metropolis < thr);
      end
    end
    model_idx = idx;
    exp_q.push_back({acc, DELTA_W'(dl), o});
    t0_q.push_back(cyc);
  endtask

  // ---------------- monitor / traces ----------------
  logic [CITY_W-1:0]   ord_tr [16];
  logic [2*CITY_W-1:0] dist_tr [16];
  logic [EXP_AW-1:0]   exp_tr [16];
  int                  trace_t0 = -100;

  always @(negedge clk) begin : mon
    int rel;
    logic [EXP_W-1:0] e;
    int t;
    rel = cyc - trace_t0;
    if (rel >= 0 && rel < 16) begin
      ord_tr[rel]  = ord_addr;
      dist_tr[rel] = dist_addr;
      exp_tr[rel]  = exp_addr;
    end
    if (!reset && bus.opt_valid && bus.busy) viol++;
    if (!reset && bus.res_valid) begin
      n_res++;
      if (exp_q.size() == 0) check("unexpected_res", bus.res_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        t = t0_q.pop_front();
        check("res_accept", bus.accept, e[EXP_W-1]);
        check("res_delta", {bus.delta}, e[EXP_W-2:OPT_W]);
        check("res_opt", bus.res_opt, e[OPT_W-1:0]);
        check("latency", cyc - t, 14);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic opt_t mk(input com_t c, input int k, input int l, input logic [31:0] r);
    opt_t o;
    o.com          = c;
    o.base_id      = BASE_W'($urandom);
    o.k            = CITY_W'(k);
    o.l            = CITY_W'(l);
    o.r_metropolis = r;
    o.r_exchange   = $urandom;
    return o;
  endfunction

  task automatic send(input opt_t o, input logic [BETA_W-1:0] b, input bit track);
    assert (o.com != COM_TWO || o.k != o.l) else $error("stimulus with K==L");
    @(posedge clk); #1;
    bus.opt = o; bus.beta = b; bus.opt_valid = 1'b1;
    if (track) begin
      push_expect(o, b);
      trace_t0 = cyc;
    end
    @(posedge clk); #1;
    bus.opt_valid = 1'b0;
  endtask

  task automatic wait_result(input int n0);
    int k = 0;
    while (n_res == n0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("result_seen", n_res - n0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_move(input opt_t o, input logic [BETA_W-1:0] b);
    int n0 = n_res;
    send(o, b, 1'b1);
    wait_result(n0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2*CITY_W-1:0] exp_da [4];
    logic [CITY_W-1:0]   exp_oa [4];
    logic [31:0]         acc_or;
    int n0, v0, k, l;

    bus.opt_valid = 1'b0; bus.opt = '0; bus.beta = '0;
    reset = 1'b1; exp_mode = 0; exp_const = '0;
    for (int i = 0; i < NC; i++) begin
      ord_mem[i] = CITY_W'(i);
      xc[i] = $urandom_range(0, 200);
      yc[i] = $urandom_range(0, 200);
    end
    ord_mem[CITY_NUM + 1] = '0;
    fill_dist();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_accept", bus.accept, 1'b0);
    check("rst_delta", {bus.delta}, 0);
    check("rst_ord_addr", ord_addr, 0);
    check("rst_dist_addr", dist_addr, 0);
    check("rst_exp_addr", exp_addr, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Identity tour, Euclidean distances, K=2 L=5
    run_move(mk(COM_TWO, 2, 5, $urandom), 16'd256);
    exp_oa = '{5'd1, 5'd2, 5'd5, 5'd6};
    exp_da = '{{5'd1, 5'd5}, {5'd2, 5'd6}, {5'd1, 5'd2}, {5'd5, 5'd6}};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ord_addr_%0d", i), ord_tr[1 + i], exp_oa[i]);
      check($sformatf("dist_addr_%0d", i), dist_tr[6 + i], exp_da[i]);
    end
    check("exp_addr_euclid", exp_tr[12], EXP_AW'(model_idx));

    // delta = -7, exp table contents unknown
    dist_mem[1][5] = 16'd10; dist_mem[2][6] = 16'd10;
    dist_mem[1][2] = 16'd12; dist_mem[5][6] = 16'd15;
    exp_mode = 2;
    run_move(mk(COM_TWO, 2, 5, $urandom), 16'($urandom));
    check("exp_addr_downhill", exp_tr[12], 0);

    // delta = +3, beta = 1.0, threshold 0x8000_0000
    dist_mem[1][5] = 16'd13; dist_mem[2][6] = 16'd10;
    dist_mem[1][2] = 16'd10; dist_mem[5][6] = 16'd10;
    exp_mode = 1; exp_const = 32'h8000_0000;
    run_move(mk(COM_TWO, 2, 5, 32'h7FFF_FFFF), 16'd256);
    check("exp_addr_plus3", exp_tr[12], 3);
    run_move(mk(COM_TWO, 2, 5, 32'h8000_0000), 16'd256);

    // delta*beta beyond the table
    dist_mem[1][5] = 16'd60000; dist_mem[2][6] = 16'd60000;
    dist_mem[1][2] = 16'd1;     dist_mem[5][6] = 16'd1;
    exp_const = 32'h0;
    run_move(mk(COM_TWO, 2, 5, $urandom), 16'hFFFF);
    check("exp_addr_sat", exp_tr[12], (1 << EXP_AW) - 1);
    fill_dist();
    exp_mode = 0;

    // Edge indices K=1, L=CITY_NUM
    run_move(mk(COM_TWO, 1, CITY_NUM, $urandom), 16'd300);
    exp_oa = '{5'd0, 5'd1, 5'd30, 5'd31};
    for (int i = 0; i < 4; i++)
      check($sformatf("ord_edge_%0d", i), ord_tr[1 + i], exp_oa[i]);

    // THR command: no reads
    run_move(mk(COM_THR, 3, 9, $urandom), 16'd512);
    acc_or = '0;
    for (int i = 1; i <= 14; i++) acc_or |= 32'(ord_tr[i]) | 32'(dist_tr[i]) | 32'(exp_tr[i]);
    check("thr_no_addr", acc_or, 0);

    // Second opt_valid on cycle 5 is ignored
    n0 = n_res; v0 = viol;
    send(mk(COM_TWO, 4, 11, $urandom), 16'd200, 1'b1);
    repeat (4) @(posedge clk); #1;
    bus.opt = mk(COM_TWO, 7, 20, $urandom); bus.opt_valid = 1'b1;
    @(posedge clk); #1 bus.opt_valid = 1'b0;
    wait_result(n0);
    check("busy_valid_flag", viol - v0, 1);

    // opt_valid on the DONE cycle is not taken
    n0 = n_res; v0 = viol;
    send(mk(COM_TWO, 6, 15, $urandom), 16'd128, 1'b1);
    repeat (13) @(posedge clk); #1;
    bus.opt = mk(COM_TWO, 8, 12, $urandom); bus.opt_valid = 1'b1;
    @(posedge clk); #1 bus.opt_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("done_valid_ignored", n_res - n0, 1);
    check("done_valid_flag", viol - v0, 1);

    // Reset on cycle 7 aborts the move
    n0 = n_res;
    send(mk(COM_TWO, 3, 17, $urandom), 16'd256, 1'b1);
    repeat (6) @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    t0_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_accept", bus.accept, 1'b0);
    check("abort_delta", {bus.delta}, 0);
    repeat (20) @(negedge clk);
    check("abort_no_res", n_res - n0, 0);
    run_move(mk(COM_TWO, 3, 17, $urandom), 16'd256);

    // Random moves on the Euclidean table
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(1, CITY_NUM - 1);
      l = $urandom_range(k + 1, CITY_NUM);
      run_move(mk(COM_TWO, k, l, $urandom), 16'($urandom_range(0, 2047)));
      check($sformatf("exp_addr_rand_%0d", i), exp_tr[12], EXP_AW'(model_idx));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
